// File: rtl/cu_prefetch_stream_responder_pkg.sv
// +----------------------------------------------------------------------------+
// | cu_prefetch_stream_responder_pkg: shared types for the prefetch responder  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package cu_prefetch_stream_responder_pkg;

  localparam int RESPONDER_FIFO_DEPTH    = 16;
  localparam int RESPONDER_ALFULL_MARGIN = 4;

  localparam logic [7:0] PREFETCH_READ_CONTROL_ID = 8'h03;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    DONE     = 2'd1,
    FAILED   = 2'd2
  } response_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } responder_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] real_size;
    logic [7:0]  cu_id;
    logic [3:0]  cmd_type;
    logic [63:0] address_offest;
    logic [31:0] array_struct;
    logic [2:0]  abt;
  } CommandBufferLine;

  typedef struct packed {
    logic             valid;
    CommandBufferLine cmd;
    response_t        response;
  } ResponseBufferLine;

  typedef struct packed {
    logic valid;
    logic alfull;
    logic full;
    logic empty;
  } BufferStatus;

endpackage

`default_nettype wire

// File: rtl/cu_prefetch_stream_responder_if.sv
// +----------------------------------------------------------------------------+
// | cu_prefetch_stream_responder_if: command/status/response bundle            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface cu_prefetch_stream_responder_if;
  import cu_prefetch_stream_responder_pkg::*;

  CommandBufferLine  command_in;
  BufferStatus       command_buffer_status;
  ResponseBufferLine response_out;

  modport master (
    output command_in,
    input  command_buffer_status,
    input  response_out
  );

  modport slave (
    input  command_in,
    output command_buffer_status,
    output response_out
  );
endinterface

`default_nettype wire

// File: rtl/cu_prefetch_stream_responder_cmd_fifo.sv
// +----------------------------------------------------------------------------+
// | cu_prefetch_cmd_fifo: synchronous FIFO, head visible only once written     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cu_prefetch_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  wire logic                     clock,
  input  wire logic                     rstn,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         push_data,
  input  wire logic                     pop,
  output logic      [WIDTH-1:0]         pop_data,
  output logic      [$clog2(DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/cu_prefetch_stream_responder.sv
// +----------------------------------------------------------------------------+
// | cu_prefetch_stream_responder: answers buffered prefetch commands in order  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cu_prefetch_stream_responder
  import cu_prefetch_stream_responder_pkg::*;
#(
  parameter int         CMD_FIFO_DEPTH  = RESPONDER_FIFO_DEPTH,
  parameter int         ALFULL_MARGIN   = RESPONDER_ALFULL_MARGIN,
  parameter logic [7:0] CU_RESPONDER_ID = PREFETCH_READ_CONTROL_ID
) (
  input  wire logic                   clock,
  input  wire logic                   rstn,
  input  wire logic                   enabled_in,
  input  wire logic [7:0]             response_latency,
  cu_prefetch_stream_responder_if.slave bus,
  output logic      [31:0]            responses_sent,
  output logic                        cmd_dropped
);

  localparam int CW = $clog2(CMD_FIFO_DEPTH) + 1;

  logic             enabled;
  CommandBufferLine cmd_q;
  CommandBufferLine head;
  CommandBufferLine held;
  logic [CW-1:0]    count;
  logic [CW-1:0]    free_entries;
  logic             fifo_full;
  logic             fifo_empty;
  logic             id_match;
  logic             push;
  logic             pop;
  logic             drop;
  logic [7:0]       lat_cnt;
  responder_state_t state;
  BufferStatus      status_r;
  ResponseBufferLine response_r;

  assign id_match     = (cmd_q.cu_id == CU_RESPONDER_ID);
  assign push         = cmd_q.valid & enabled & ~fifo_full & id_match;
  assign drop         = cmd_q.valid & (fifo_full | ~id_match);
  assign pop          = (state == IDLE) & enabled & ~fifo_empty;
  assign free_entries = CW'(CMD_FIFO_DEPTH) - count;

  assign bus.command_buffer_status = status_r;
  assign bus.response_out          = response_r;

  cu_prefetch_cmd_fifo #(
    .DEPTH (CMD_FIFO_DEPTH),
    .WIDTH ($bits(CommandBufferLine))
  ) u_fifo (
    .clock     (clock),
    .rstn      (rstn),
    .push      (push),
    .push_data (cmd_q),
    .pop       (pop),
    .pop_data  (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      enabled     <= 1'b0;
      cmd_q       <= '0;
      cmd_dropped <= 1'b0;
      status_r    <= '{valid: 1'b0, alfull: 1'b0, full: 1'b0, empty: 1'b1};
    end else begin
      enabled  <= enabled_in;
      cmd_q    <= bus.command_in;
      if (drop) cmd_dropped <= 1'b1;
      status_r <= '{valid:  enabled,
                    alfull: (free_entries <= CW'(ALFULL_MARGIN)),
                    full:   fifo_full,
                    empty:  fifo_empty};
    end
  end

  // WAIT and RESPOND ignore enable so an in-flight command always completes.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      lat_cnt        <= 8'd0;
      held           <= '0;
      response_r     <= '0;
      responses_sent <= 32'd0;
    end else begin
      response_r <= '0;
      case (state)
        IDLE: begin
          if (pop) begin
            held    <= head;
            lat_cnt <= (response_latency == 8'd0) ? 8'd0 : response_latency - 8'd1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 8'd0) begin
            response_r     <= '{valid: 1'b1, cmd: held, response: DONE};
            responses_sent <= responses_sent + 32'd1;
            state          <= RESPOND;
          end else begin
            lat_cnt <= lat_cnt - 8'd1;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cu_prefetch_stream_responder.sv
// +----------------------------------------------------------------------------+
// | tb_cu_prefetch_stream_responder: scoreboard bench for the prefetch responder|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cu_prefetch_stream_responder;
  import cu_prefetch_stream_responder_pkg::*;

  logic        clock = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled_in = 1'b0;
  logic [7:0]  response_latency = 8'd0;
  logic [31:0] responses_sent;
  logic        cmd_dropped;

  cu_prefetch_stream_responder_if bus ();

  cu_prefetch_stream_responder dut (
    .clock            (clock),
    .rstn             (rstn),
    .enabled_in       (enabled_in),
    .response_latency (response_latency),
    .bus              (bus.slave),
    .responses_sent   (responses_sent),
    .cmd_dropped      (cmd_dropped)
  );

  always #5 clock = ~clock;

  int               n_cmp = 0;
  int               n_err = 0;
  longint           cyc = 0;
  longint           last_rsp = -1;
  int               exp_gap = 0;
  int               rsp_cnt = 0;
  CommandBufferLine exp_q[$];
  CommandBufferLine mon_e;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rstn && bus.response_out.valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_offset", bus.response_out.cmd.address_offest, mon_e.address_offest);
        check("rsp_size",   bus.response_out.cmd.real_size, mon_e.real_size);
        check("rsp_abt",    bus.response_out.cmd.abt, mon_e.abt);
        check("rsp_code",   bus.response_out.response, DONE);
        if (exp_gap != 0 && last_rsp >= 0)
          check("rsp_gap", cyc - last_rsp, exp_gap);
      end
      last_rsp = cyc;
    end
  end

  function automatic CommandBufferLine make_cmd(input logic [63:0] off, input logic [7:0] id);
    CommandBufferLine c;
    c.valid          = 1'b1;
    c.real_size      = 32'd128;
    c.cu_id          = id;
    c.cmd_type       = 4'h2;
    c.address_offest = off;
    c.array_struct   = 32'hA5A5_0000 | off[31:0];
    c.abt            = off[2:0] ^ 3'd5;
    return c;
  endfunction

  task automatic send(input logic [63:0] off, input logic [7:0] id, input bit accept);
    CommandBufferLine c;
    c = make_cmd(off, id);
    @(posedge clock); #1;
    bus.command_in = c;
    if (accept) exp_q.push_back(c);
  endtask

  task automatic idle(input int n);
    @(posedge clock); #1;
    bus.command_in = '0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clock);
    repeat (4) @(posedge clock);
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int base;
    bit seen;
    bus.command_in = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_response", bus.response_out, 0);
    check("rst_sent", responses_sent, 0);
    check("rst_dropped", cmd_dropped, 0);
    check("rst_status", bus.command_buffer_status, 4'b0001);
    @(negedge clock); rstn = 1'b1;
    enabled_in = 1'b1;
    idle(2);
    check("en_status_valid", bus.command_buffer_status, 4'b1001);

    // latency 0: five in-order responses three cycles apart
    response_latency = 8'd0;
    exp_gap = 3; last_rsp = -1;
    for (int i = 0; i < 5; i++) send(64'(i * 128), PREFETCH_READ_CONTROL_ID, 1'b1);
    idle(1);
    drain("t1_drain", 100);
    check("t1_sent", responses_sent, 5);
    check("t1_empty", bus.command_buffer_status.empty, 1);
    check("t1_dropped", cmd_dropped, 0);

    // latency 10: 20 back-to-back; the last two meet a full buffer
    response_latency = 8'd10;
    exp_gap = 12; last_rsp = -1;
    for (int i = 0; i < 20; i++) send(64'h1000 + 64'(i * 64), PREFETCH_READ_CONTROL_ID, i < 18);
    idle(1);
    check("t2_full", bus.command_buffer_status.full, 1);
    check("t2_alfull", bus.command_buffer_status.alfull, 1);
    check("t2_dropped", cmd_dropped, 1);
    drain("t2_drain", 400);
    check("t2_sent", responses_sent, 23);
    check("t2_alfull_clr", bus.command_buffer_status.alfull, 0);

    // push and pop on the same edge at occupancy 8
    response_latency = 8'd20;
    exp_gap = 0;
    for (int i = 0; i < 9; i++) send(64'h8000 + 64'(i * 32), PREFETCH_READ_CONTROL_ID, 1'b1);
    idle(1);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      seen = bus.response_out.valid;
    end
    check("t3_seen", seen, 1);
    check("t3_count_before", dut.u_fifo.count, 8);
    bus.command_in = make_cmd(64'h9000, PREFETCH_READ_CONTROL_ID);
    exp_q.push_back(bus.command_in);
    @(posedge clock); #1;
    bus.command_in = '0;
    @(posedge clock); #1;
    check("t3_count_after", dut.u_fifo.count, 8);
    drain("t3_drain", 400);
    check("t3_sent", responses_sent, 33);

    // disable while in WAIT: current response completes, rest held
    response_latency = 8'd10;
    base = rsp_cnt;
    for (int i = 0; i < 4; i++) send(64'hA000 + 64'(i * 16), PREFETCH_READ_CONTROL_ID, 1'b1);
    idle(3);
    enabled_in = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    check("t5_one_rsp", rsp_cnt - base, 1);
    check("t5_held", dut.u_fifo.count, 3);
    check("t5_status_invalid", bus.command_buffer_status.valid, 0);
    enabled_in = 1'b1;
    drain("t5_drain", 200);
    check("t5_total", rsp_cnt - base, 4);
    check("t5_sent", responses_sent, 37);

    // asynchronous reset during WAIT with six queued
    for (int i = 0; i < 7; i++) send(64'hB000 + 64'(i * 16), PREFETCH_READ_CONTROL_ID, 1'b1);
    idle(3);
    rstn = 1'b0;
    @(negedge clock);
    check("t6_response", bus.response_out, 0);
    check("t6_sent", responses_sent, 0);
    check("t6_dropped", cmd_dropped, 0);
    check("t6_status", bus.command_buffer_status, 4'b0001);
    exp_q.delete();
    base = rsp_cnt;
    @(negedge clock); rstn = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    check("t6_no_stale", rsp_cnt - base, 0);
    check("t6_sent_after", responses_sent, 0);
    check("t6_empty", bus.command_buffer_status.empty, 1);

    // foreign cu_id is dropped and never answered
    base = rsp_cnt;
    send(64'hC000, 8'h07, 1'b0);
    idle(10);
    check("t4_dropped", cmd_dropped, 1);
    check("t4_count", dut.u_fifo.count, 0);
    check("t4_no_rsp", rsp_cnt - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
